pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Fetch stage of the SCU ISA pipeline, directly downstream of the 2:1 PC-select mux.
//  Registers the mux output as the program counter and drives the instruction memory address.
//  Produces PC+PC_INC, which is fed back to mux input A; mux input B carries the branch target.
//  Captures the fetched instruction into the IF/ID pipeline register.
//  Handles stall, flush and post-flush bubble insertion with a small state machine.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  PC_INC        1              PC increment per fetch (word-addressed instruction memory)
//  FLUSH_BUBBLES 1              bubbles (valid=0) forced after a flush, range 1..7
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  next_pc        in   32  PC-select mux output (PC+PC_INC or branch target)
//  stall          in   1   hold PC and IF/ID contents (load-use hazard from decode)
//  flush          in   1   branch taken: discard IF/ID contents, insert bubbles
//  imem_rdata     in   32  instruction word at imem_addr, combinational read
//  imem_addr      out  32  current PC, also the fetch address
//  pc_plus_inc    out  32  imem_addr + PC_INC, drives mux input A
//  if_id_pc       out  32  PC of the instruction held in IF/ID
//  if_id_instr    out  32  instruction held in IF/ID
//  if_id_valid    out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset values: imem_addr=RESET_PC, if_id_pc=0, if_id_instr=0 (NOP), if_id_valid=0,
//    state=S_BOOT, bubble count=0. Reset overrides all other inputs; an asserted reset
//    mid-stall or mid-flush returns every output to its reset value on the next edge.
//  - States:
//    - S_BOOT: one cycle after reset. PC is held and the IF/ID register stays invalid,
//      so the first instruction is not fetched from an unsettled memory. Next state is S_RUN.
//    - S_RUN, stall=0, flush=0: pc<=next_pc, if_id<={imem_addr, imem_rdata}, valid<=1.
//    - S_RUN, stall=1, flush=0: pc and IF/ID hold, valid holds.
//    - S_RUN, flush=1: pc<=next_pc, if_id_instr<=0, valid<=0, count<=FLUSH_BUBBLES-1.
//      Go to S_BUBBLE if FLUSH_BUBBLES>1, otherwise stay in S_RUN.
//    - S_BUBBLE: pc advances normally (pc<=next_pc) and valid<=0.
//      Each cycle decrements count; when count==0 at the edge, go to S_RUN.
//  - Simultaneous events:
//    - flush and stall together: flush wins and stall is ignored for that cycle.
//    - flush during S_BUBBLE: the bubble count is reloaded to FLUSH_BUBBLES-1.
//    - stall during S_BUBBLE: PC and count both hold.
//  - Arithmetic: pc_plus_inc = imem_addr + PC_INC, modulo 2^32.
//    Wrap from 32'hFFFF_FFFF to 0 is legal and silent.
//  - Latency: an instruction at address A appears on if_id_* one edge after imem_addr==A,
//    absent stall or flush.
//  - if_id_pc is updated only with if_id_instr; a bubble keeps the last if_id_pc value.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_stall[31:0].
//    - perf_fetched counts edges where valid<=1 is loaded.
//    - perf_stall counts cycles with stall=1 && flush=0 && !rst.
//    - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
//  - FETCH_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour
//    is identical.
// TESTING
//  1. rst=1 for 2 cycles, then release.
//     -> imem_addr=0 and valid=0 through the S_BOOT cycle; first valid instruction 2 edges
//        after release, with if_id_pc=0.
//  2. next_pc=pc_plus_inc, imem returns addr+32'h100 for 4 cycles.
//     -> if_id_pc sequence 0,1,2,3; if_id_instr sequence 100,101,102,103 (hex).
//  3. stall=1 for 3 cycles at pc=5.
//     -> imem_addr stays 5 and the IF/ID contents are unchanged for 3 cycles;
//        after release, fetch resumes at 5.
//  4. flush=1 and stall=1 together with next_pc=32'h40, FLUSH_BUBBLES=2.
//     -> imem_addr=32'h40; valid=0 for 2 cycles; then if_id_pc=32'h40, valid=1.
//  5. pc=32'hFFFF_FFFF with no branch.
//     -> pc_plus_inc=0 and the next imem_addr=0; no error.
//  6. FETCH_PERF_CNT_EN defined: 5 fetches, then 2 stalls, then rst.
//     -> perf_fetched=5 and perf_stall=2; both read 0 after reset.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, PC+PC_INC feedback, IF/ID pipeline register with stall/flush/bubble control.
// Optional FETCH_PERF_CNT_EN adds saturating fetch and stall counters (perf_fetched, perf_stall).
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] PC_INC        = 32'd1,
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus_inc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_BUBBLE = 2'd2;

    localparam logic [2:0] BUBBLE_RELOAD = 3'(FLUSH_BUBBLES - 1);

    logic [1:0] state;
    logic [2:0] count;
    logic       fetch_load;

    assign pc_plus_inc = imem_addr + PC_INC;
    assign fetch_load  = (state == S_RUN) && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr   <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            state       <= S_BOOT;
            count       <= '0;
        end else if (state == S_BOOT) begin
            state <= S_RUN;
        end else if (flush) begin
            imem_addr   <= next_pc;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            count       <= BUBBLE_RELOAD;
            state       <= (FLUSH_BUBBLES > 1) ? S_BUBBLE : S_RUN;
        end else if (fetch_load) begin
            imem_addr   <= next_pc;
            if_id_pc    <= imem_addr;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
        end else if (state == S_BUBBLE && !stall) begin
            // count holds the bubble edges still owed; the last one hands back to S_RUN
            imem_addr   <= next_pc;
            if_id_valid <= 1'b0;
            count       <= count - 3'd1;
            if (count <= 3'd1) begin
                state <= S_RUN;
            end
        end else if (state != S_RUN && state != S_BUBBLE) begin
            state <= S_RUN;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fetch_load && perf_fetched != '1) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && !flush && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: a rule-level model pushes expected per-cycle outputs,
// a negedge monitor pops and compares them. Perf counters are checked when FETCH_PERF_CNT_EN is defined.
module tb_pc_fetch_stage;

    localparam int unsigned FB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus_inc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    // instruction memory: word at address A is A + 0x100
    assign imem_rdata = imem_addr + 32'h100;

    pc_fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .PC_INC       (32'd1),
        .FLUSH_BUBBLES(FB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc_plus_inc(pc_plus_inc),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pf;
        logic [31:0] ps;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc = '0, m_ifpc = '0, m_instr = '0, m_pf = '0, m_ps = '0;
    logic        m_valid = 1'b0;
    logic        m_boot = 1'b1;
    int unsigned m_bub = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] np);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r; stall = s; flush = f; next_pc = np;
        if (r) begin
            m_pc = '0; m_ifpc = '0; m_instr = '0; m_valid = 1'b0;
            m_boot = 1'b1; m_bub = 0; m_pf = '0; m_ps = '0;
        end else begin
            if (s && !f && m_ps != 32'hFFFF_FFFF) m_ps = m_ps + 1;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (f) begin
                m_pc = np; m_instr = '0; m_valid = 1'b0; m_bub = FB - 1;
            end else if (s) begin
                // everything holds
            end else if (m_bub > 0) begin
                m_pc = np; m_valid = 1'b0; m_bub = m_bub - 1;
            end else begin
                m_ifpc = m_pc; m_instr = m_pc + 32'h100; m_valid = 1'b1; m_pc = np;
                if (m_pf != 32'hFFFF_FFFF) m_pf = m_pf + 1;
            end
        end
        e.addr = m_pc; e.inc = m_pc + 32'd1; e.ifpc = m_ifpc; e.instr = m_instr;
        e.valid = m_valid; e.pf = m_pf; e.ps = m_ps;
        sb.push_back(e);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, m_pc + 32'd1);
    endtask

    // monitor: outputs after each edge compared against the oldest pending expectation
    initial begin
        exp_t e;
        @(posedge clk);
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("pc_plus_inc", pc_plus_inc, e.inc);
                chk("if_id_pc", if_id_pc, e.ifpc);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
`ifdef FETCH_PERF_CNT_EN
                chk("perf_fetched", perf_fetched, e.pf);
                chk("perf_stall", perf_stall, e.ps);
`endif
            end
        end
    end

    initial begin
        logic r, s, f;
        logic [31:0] np;
        // reset for 2 cycles, boot cycle, then sequential fetch
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        seq(5);
        for (int i = 0; i < 20 && m_pc != 32'd5; i++) seq(1);
        // stall at pc=5, next_pc deliberately noisy while held
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, $urandom);
        seq(3);
        // flush and stall together, branch target held through the bubble
        step(1'b0, 1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 8 && m_bub > 0; i++) step(1'b0, 1'b0, 1'b0, 32'h40);
        seq(3);
        // branch to the top of the address space and wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 8 && m_bub > 0; i++) step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        seq(3);
        // stall in the middle of a bubble, then flush again during the bubble
        step(1'b0, 1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b1, 1'b0, 32'h999);
        step(1'b0, 1'b0, 1'b1, 32'h300);
        seq(4);
        // reset asserted mid-flush
        step(1'b0, 1'b0, 1'b1, 32'h500);
        step(1'b1, 1'b0, 1'b0, 32'h77);
        seq(2);
        // perf scenario: 5 fetches, 2 stalls, then reset
        seq(5);
        step(1'b0, 1'b1, 1'b0, m_pc + 32'd1);
        step(1'b0, 1'b1, 1'b0, m_pc + 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(99) == 0);
            f = ($urandom_range(9) == 0);
            s = ($urandom_range(5) == 0);
            np = ($urandom_range(9) == 0 || f) ? $urandom : m_pc + 32'd1;
            step(r, s, f, np);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
